// File: rtl/gearbox_pkg.sv
// Shared definitions for the 2x gearboxes: downsizer state encoding and the
// half-order convention used by both the upsizing and downsizing sides.
package gearbox_pkg;

  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} gearbox_down_state_t;

  localparam logic HALF_HI = 1'b1;

  // Upper half is selected for the first beat when msb_first is set, and for
  // the second beat otherwise.
  function automatic logic half_sel(input logic msb_first, input logic second_half);
    return msb_first ^ second_half;
  endfunction

endpackage

// File: rtl/gearbox_downsizing_2x.sv
// Narrowing gearbox: one 2*nb-bit word in, two nb-bit beats out.
// Optional tlast passthrough is enabled with GEARBOX_DOWNSIZING_TLAST_EN.
module gearbox_downsizing_2x
  import gearbox_pkg::*;
#(
  parameter int n         = 5,
  parameter int nb        = n * 8,
  parameter bit msb_first = 1'b0
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [2*nb-1:0] in_tdata,
  input  logic            in_tvalid,
  output logic            in_tready,
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
  input  logic            in_tlast,
  output logic            out_tlast,
`endif
  output logic [nb-1:0]   out_tdata,
  output logic            out_tvalid,
  input  logic            out_tready
);

  gearbox_down_state_t state, state_next;
  logic [2*nb-1:0]     hold;
  logic                load;
  logic                sel_hi;

  // The only combinational path through the block: out_tready -> in_tready.
  assign in_tready = (state == EMPTY) | ((state == SECOND) & out_tready);
  assign load      = in_tvalid & in_tready;

  always_comb begin
    // NOTE: assign a default before the case so every path drives state_next
    // and no latch is inferred.
    state_next = state;
    case (state)
      EMPTY:   if (in_tvalid)  state_next = FIRST;
      FIRST:   if (out_tready) state_next = SECOND;
      SECOND:  if (out_tready) state_next = in_tvalid ? FIRST : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (areset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: the data register carries no reset; out_tdata is masked while EMPTY,
  // so its power-up contents are never visible.
  always_ff @(posedge aclk) begin
    if (load) hold <= in_tdata;
  end

  assign sel_hi     = (half_sel(msb_first, state == SECOND) == HALF_HI);
  assign out_tvalid = (state != EMPTY);
  assign out_tdata  = (state == EMPTY) ? '0 : (sel_hi ? hold[2*nb-1:nb] : hold[nb-1:0]);

`ifdef GEARBOX_DOWNSIZING_TLAST_EN
  logic tlast_q;

  always_ff @(posedge aclk) begin
    if (areset)    tlast_q <= 1'b0;
    else if (load) tlast_q <= in_tlast;
  end

  // tlast belongs to the last narrow beat of the word only.
  assign out_tlast = (state == SECOND) & tlast_q;
`endif

endmodule

// File: tb/tb_gearbox_downsizing_2x.sv
// Directed bench for gearbox_downsizing_2x (n=5, msb_first=0) with a queue
// of expected narrow beats for the streaming phases.
module tb_gearbox_downsizing_2x;

  localparam int NB = 40;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [2*NB-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [NB-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
  logic          in_tlast = 1'b0;
  logic          out_tlast;
  logic          sb_last[$];
`endif

  int total = 0;
  int bad   = 0;
  logic [NB-1:0] sb[$];

  always #5 aclk = ~aclk;

  gearbox_downsizing_2x #(.n(5), .msb_first(1'b0)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
    .in_tlast   (in_tlast),
    .out_tlast  (out_tlast),
`endif
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  task automatic check(input string tag, input logic [2*NB-1:0] obs, input logic [2*NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Streams `words` words; vpct/rpct are percent chances of offering a word
  // and of accepting a beat. last_word marks the word carrying tlast.
  task automatic run_stream(input int words, input int vpct, input int rpct,
                            input bit gapcheck, input int last_word);
    int sent = 0, got = 0, cyc = 0;
    bit pending = 1'b0, stalled = 1'b0;
    logic [NB-1:0] prev = '0;
    while (got < 2 * words && cyc < 4000) begin
      if (!pending && sent < words && $urandom_range(99) < vpct) begin
        in_tdata  = {$urandom(), $urandom(), 16'($urandom())};
        in_tvalid = 1'b1;
        pending   = 1'b1;
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
        in_tlast  = (sent == last_word);
`endif
      end else if (!pending) begin
        in_tvalid = 1'b0;
      end
      out_tready = ($urandom_range(99) < rpct);
      #1;
      if (gapcheck && cyc > 0) check("no_gap", out_tvalid, 1'b1);
      if (stalled) begin
        check("stall_valid", out_tvalid, 1'b1);
        check("stall_data", out_tdata, prev);
      end
      if (out_tvalid && out_tready) begin
        if (sb.size() == 0) check("extra_beat", 1'b1, 1'b0);
        else check("beat_data", out_tdata, sb.pop_front());
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
        if (sb_last.size() != 0) check("beat_last", out_tlast, sb_last.pop_front());
`endif
        got++;
      end
      stalled = out_tvalid && !out_tready;
      prev    = out_tdata;
      if (in_tvalid && in_tready) begin
        sb.push_back(in_tdata[NB-1:0]);
        sb.push_back(in_tdata[2*NB-1:NB]);
`ifdef GEARBOX_DOWNSIZING_TLAST_EN
        sb_last.push_back(1'b0);
        sb_last.push_back(sent == last_word);
`endif
        sent++;
        pending = 1'b0;
      end
      tick();
      cyc++;
    end
    in_tvalid = 1'b0;
    check("beat_count", 32'(got), 32'(2 * words));
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    out_tready = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", out_tvalid, 1'b0);
      check("idle_data", out_tdata, '0);
      check("idle_ready", in_tready, 1'b1);
    end

    // Single word, low half first.
    in_tdata  = 80'hAAAAAAAAAA_5555555555;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    #1;
    check("w1_first_valid", out_tvalid, 1'b1);
    check("w1_first_data", out_tdata, 40'h5555555555);
    check("w1_first_ready", in_tready, 1'b0);
    tick();
    check("w1_second_valid", out_tvalid, 1'b1);
    check("w1_second_data", out_tdata, 40'hAAAAAAAAAA);
    check("w1_second_ready", in_tready, 1'b1);
    tick();
    check("w1_empty_valid", out_tvalid, 1'b0);
    check("w1_empty_data", out_tdata, '0);

    run_stream(100, 100, 100, 1'b1, -1);
    run_stream(60, 60, 50, 1'b0, -1);

    // Reset while the first half is stalled; the second half must vanish.
    in_tdata   = 80'h0123456789_ABCDEF0123;
    in_tvalid  = 1'b1;
    out_tready = 1'b0;
    tick();
    in_tvalid = 1'b0;
    #1;
    check("rst_pre_valid", out_tvalid, 1'b1);
    check("rst_pre_data", out_tdata, 40'hABCDEF0123);
    tick();
    check("rst_hold_data", out_tdata, 40'hABCDEF0123);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    check("rst_valid", out_tvalid, 1'b0);
    check("rst_data", out_tdata, '0);
    check("rst_ready", in_tready, 1'b1);
    out_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_resume", out_tvalid, 1'b0);
    end
    in_tdata  = 80'hFEDCBA9876_1122334455;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    #1;
    check("post_rst_first", out_tdata, 40'h1122334455);
    tick();
    check("post_rst_second", out_tdata, 40'hFEDCBA9876);
    tick();
    check("post_rst_empty", out_tvalid, 1'b0);

`ifdef GEARBOX_DOWNSIZING_TLAST_EN
    // tlast on the third of four words lands on narrow beat 6 only.
    run_stream(4, 100, 100, 1'b1, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
